// File: rtl/rename_freelist.sv
// Physical-register free list with multi-slot allocate, multi-port release and branch checkpoints.
// Latency: grant and pregs are same-cycle combinational; state, ckpt_valid and num_free update at the edge.
// Backpressure: allocation is all-or-nothing (alloc_grant=0 holds state); checkpoint takes are dropped unless granted.
// Optional FREELIST_ZERO_PREG_EN: preg 0 is hardwired zero and never enters the free pool.
module rename_freelist #(
  parameter int NUM_PREGS   = 64,
  parameter int RESET_USED  = 32,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2,
  parameter int NUM_CKPT    = 4,
  parameter int PW          = $clog2(NUM_PREGS),
  parameter int CW          = $clog2(NUM_CKPT),
  parameter int SW          = $clog2(ALLOC_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ALLOC_WIDTH-1:0]      alloc_req,
  output logic                        alloc_grant,
  output logic [ALLOC_WIDTH*PW-1:0]   alloc_preg,
  input  logic                        ckpt_take,
  input  logic [CW-1:0]               ckpt_id,
  input  logic [SW-1:0]               ckpt_slot,
  input  logic [FREE_WIDTH-1:0]       rel_valid,
  input  logic [FREE_WIDTH*PW-1:0]    rel_preg,
  input  logic                        resolve_valid,
  input  logic [CW-1:0]               resolve_id,
  input  logic                        shootdown_valid,
  input  logic [CW-1:0]               shootdown_id,
  input  logic [NUM_CKPT-1:0]         kill_mask,
  output logic [NUM_CKPT-1:0]         ckpt_valid,
  output logic [PW:0]                 num_free
);

  // Pregs that may ever sit in the free pool.
`ifdef FREELIST_ZERO_PREG_EN
  localparam logic [NUM_PREGS-1:0] POOL_MASK = {{(NUM_PREGS-1){1'b1}}, 1'b0};
`else
  localparam logic [NUM_PREGS-1:0] POOL_MASK = {NUM_PREGS{1'b1}};
`endif

  function automatic logic [NUM_PREGS-1:0] reset_free_map();
    logic [NUM_PREGS-1:0] r;
    for (int i = 0; i < NUM_PREGS; i++) r[i] = (i >= RESET_USED);
    return r & POOL_MASK;
  endfunction

  function automatic logic [PW:0] popcnt(input logic [NUM_PREGS-1:0] v);
    logic [PW:0] n;
    n = '0;
    for (int i = 0; i < NUM_PREGS; i++) n = n + (PW+1)'(v[i]);
    return n;
  endfunction

  localparam logic [NUM_PREGS-1:0] RESET_FREE = reset_free_map();
  localparam logic [PW:0]          RESET_NUM  = popcnt(RESET_FREE);

  logic [NUM_PREGS-1:0] free;
  logic [NUM_PREGS-1:0] since [NUM_CKPT];

  logic [NUM_PREGS-1:0]             avail;
  logic [ALLOC_WIDTH-1:0][PW-1:0]   pick;
  logic [ALLOC_WIDTH-1:0]           pick_ok;
  logic [PW:0]                      req_cnt;
  logic [NUM_PREGS-1:0]             alloc_vec;
  logic [NUM_PREGS-1:0]             young_vec;
  logic [NUM_PREGS-1:0]             rel_vec;
  logic [NUM_PREGS-1:0]             free_nxt;
  logic [NUM_CKPT-1:0]              cv_nxt;
  logic                             take_ok;

  // Requesting slots take successive lowest-index free pregs in ascending slot order.
  always_comb begin
    avail   = free;
    pick    = '0;
    pick_ok = '0;
    req_cnt = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (alloc_req[k]) begin
        req_cnt = req_cnt + 1'b1;
        // Descending scan: the last hit is the lowest free index.
        for (int i = NUM_PREGS - 1; i >= 0; i--) begin
          if (avail[i]) begin
            pick[k]    = PW'(i);
            pick_ok[k] = 1'b1;
          end
        end
        if (pick_ok[k]) avail[pick[k]] = 1'b0;
      end
    end
  end

  assign alloc_grant = !reset && !shootdown_valid && (num_free >= req_cnt);
  assign alloc_preg  = reset ? '0 : pick;
  assign take_ok     = ckpt_take && !reset && !shootdown_valid && (alloc_grant || (alloc_req == '0));

  // Bitmaps of pregs handed out this cycle, all and branch-younger only.
  always_comb begin
    alloc_vec = '0;
    young_vec = '0;
    if (alloc_grant) begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (alloc_req[k]) begin
          alloc_vec[pick[k]] = 1'b1;
          if (k >= int'(ckpt_slot)) young_vec[pick[k]] = 1'b1;
        end
      end
    end
  end

  // Next free pool: remove grants, add releases and the shot-down checkpoint's pregs.
  always_comb begin
    rel_vec = '0;
    for (int p = 0; p < FREE_WIDTH; p++) begin
      if (rel_valid[p]) rel_vec[rel_preg[p*PW +: PW]] = 1'b1;
    end
    free_nxt = (free & ~alloc_vec) | rel_vec;
    if (shootdown_valid) free_nxt = free_nxt | since[shootdown_id];
    free_nxt = free_nxt & POOL_MASK;
  end

  // Next checkpoint liveness: resolve (unless being killed), then kill, then take.
  always_comb begin
    cv_nxt = ckpt_valid;
    if (resolve_valid && !(shootdown_valid && kill_mask[resolve_id])) cv_nxt[resolve_id] = 1'b0;
    if (shootdown_valid) cv_nxt = cv_nxt & ~kill_mask;
    if (take_ok) cv_nxt[ckpt_id] = 1'b1;
  end

  // Free bitmap, checkpoint liveness and registered free count.
  always_ff @(posedge clk) begin
    if (reset) begin
      free       <= RESET_FREE;
      ckpt_valid <= '0;
      num_free   <= RESET_NUM;
    end else begin
      free       <= free_nxt;
      ckpt_valid <= cv_nxt;
      num_free   <= popcnt(free_nxt);
    end
  end

  // Per-checkpoint record of pregs allocated younger than its branch.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CKPT; c++) begin
      if (reset) begin
        since[c] <= '0;
      end else if (take_ok && (ckpt_id == CW'(c))) begin
        since[c] <= young_vec;
      end else if (ckpt_valid[c]) begin
        since[c] <= since[c] | alloc_vec;
      end
    end
  end

  // A preg released while already in the pool indicates a retire-side bug.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < FREE_WIDTH; p++) begin
        if (rel_valid[p]) assert (!free[rel_preg[p*PW +: PW]]);
      end
    end
  end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed bench for rename_freelist with default parameters.
// Stimulus pushes expectations into a queue; a negedge monitor pops and compares.
// Every expected value below is hand-derived from the reset map (pregs 32..63 free).
module tb_rename_freelist;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  alloc_req;
  logic        alloc_grant;
  logic [11:0] alloc_preg;
  logic        ckpt_take;
  logic [1:0]  ckpt_id;
  logic [1:0]  ckpt_slot;
  logic [1:0]  rel_valid;
  logic [11:0] rel_preg;
  logic        resolve_valid;
  logic [1:0]  resolve_id;
  logic        shootdown_valid;
  logic [1:0]  shootdown_id;
  logic [3:0]  kill_mask;
  logic [3:0]  ckpt_valid;
  logic [6:0]  num_free;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    bit         cg; bit g;
    bit         cp; logic [11:0] p;
    bit         cn; int nf;
    bit         cc; logic [3:0] cv;
  } exp_t;

  exp_t q[$];
  exp_t ex;

  rename_freelist dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_preg(alloc_preg),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_slot(ckpt_slot),
    .rel_valid(rel_valid), .rel_preg(rel_preg),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id),
    .shootdown_valid(shootdown_valid), .shootdown_id(shootdown_id),
    .kill_mask(kill_mask), .ckpt_valid(ckpt_valid), .num_free(num_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic idle();
    alloc_req = 2'b00; ckpt_take = 1'b0; ckpt_id = 2'd0; ckpt_slot = 2'd2;
    rel_valid = 2'b00; rel_preg = 12'd0; resolve_valid = 1'b0; resolve_id = 2'd0;
    shootdown_valid = 1'b0; shootdown_id = 2'd0; kill_mask = 4'b0000;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
    ex.nm = ""; ex.cg = 0; ex.g = 0; ex.cp = 0; ex.p = '0;
    ex.cn = 0; ex.nf = 0; ex.cc = 0; ex.cv = '0;
  endtask

  task automatic eg(input bit g);                ex.cg = 1; ex.g = g;                    endtask
  task automatic ep(input int s1, input int s0); ex.cp = 1; ex.p = {6'(s1), 6'(s0)};     endtask
  task automatic en(input int n);                ex.cn = 1; ex.nf = n;                   endtask
  task automatic ec(input logic [3:0] v);        ex.cc = 1; ex.cv = v;                   endtask
  task automatic push(input string nm);          ex.nm = nm; q.push_back(ex);            endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.cg) chk({e.nm, "_grant"}, int'(alloc_grant), int'(e.g));
      if (e.cp) chk({e.nm, "_preg"}, int'(alloc_preg), int'(e.p));
      if (e.cn) chk({e.nm, "_num_free"}, int'(num_free), e.nf);
      if (e.cc) chk({e.nm, "_ckpt_valid"}, int'(ckpt_valid), int'(e.cv));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    // Reset state; requests ignored during reset.
    next(); reset = 1'b1; alloc_req = 2'b11; eg(0); ep(0, 0); en(32); ec(4'b0000); push("reset");
    next(); reset = 1'b0; alloc_req = 2'b11; eg(1); ep(33, 32); en(32); push("first_alloc");
    next(); en(30); push("after_first");
    // Drain down to one free preg.
    for (int i = 0; i < 14; i++) begin
      next(); alloc_req = 2'b11; eg(1); ep(35 + 2*i, 34 + 2*i); en(30 - 2*i); push("drain");
    end
    next(); alloc_req = 2'b01; eg(1); ep(0, 62); en(2); push("alloc62");
    next(); alloc_req = 2'b11; eg(0); en(1); push("short_deny");
    next(); alloc_req = 2'b01; eg(1); ep(0, 63); en(1); push("last_one");
    // Empty: request denied and checkpoint take dropped.
    next(); alloc_req = 2'b01; ckpt_take = 1'b1; ckpt_id = 2'd2; ckpt_slot = 2'd0;
    eg(0); en(0); ec(4'b0000); push("empty");
    next(); en(0); ec(4'b0000); push("empty_hold");

    // Mid-operation reset, then checkpoint/shootdown of younger pregs.
    next(); reset = 1'b1; alloc_req = 2'b11; eg(0); ep(0, 0); push("reset_mid");
    next(); reset = 1'b0; alloc_req = 2'b11; ckpt_take = 1'b1; ckpt_id = 2'd1; ckpt_slot = 2'd1;
    eg(1); ep(33, 32); en(32); ec(4'b0000); push("take1");
    next(); alloc_req = 2'b11; eg(1); ep(35, 34); en(30); ec(4'b0010); push("after_take1");
    next(); alloc_req = 2'b11; shootdown_valid = 1'b1; shootdown_id = 2'd1; kill_mask = 4'b0010;
    eg(0); en(28); ec(4'b0010); push("shoot1");
    next(); en(31); ec(4'b0000); push("after_shoot1");
    next(); alloc_req = 2'b01; eg(1); ep(0, 33); en(31); push("realloc33");
    next(); alloc_req = 2'b11; eg(1); ep(35, 34); en(30); push("realloc34");
    next(); en(28); push("settle1");

    // Two live checkpoints killed together with a same-cycle release.
    next(); ckpt_take = 1'b1; ckpt_id = 2'd0; ckpt_slot = 2'd2; en(28); ec(4'b0000); push("take0");
    next(); ckpt_take = 1'b1; ckpt_id = 2'd2; ckpt_slot = 2'd2; ec(4'b0001); push("take2");
    next(); alloc_req = 2'b11; shootdown_valid = 1'b1; shootdown_id = 2'd0; kill_mask = 4'b0101;
    rel_valid = 2'b01; rel_preg = 12'd5; resolve_valid = 1'b1; resolve_id = 2'd2;
    eg(0); en(28); ec(4'b0101); push("shoot0");
    next(); en(29); ec(4'b0000); push("after_shoot0");
    next(); alloc_req = 2'b01; eg(1); ep(0, 5); en(29); push("alloc5");
    next(); en(28); push("settle2");

    // Resolve drops a live checkpoint.
    next(); ckpt_take = 1'b1; ckpt_id = 2'd3; ckpt_slot = 2'd2; ec(4'b0000); push("take3");
    next(); resolve_valid = 1'b1; resolve_id = 2'd3; ec(4'b1000); push("resolve3");
    next(); ec(4'b0000); push("after_resolve");

    // Release of 40 is not allocatable in its own cycle.
    next(); alloc_req = 2'b11; eg(1); ep(37, 36); en(28); push("a36");
    next(); alloc_req = 2'b11; eg(1); ep(39, 38); en(26); push("a38");
    next(); alloc_req = 2'b11; eg(1); ep(41, 40); en(24); push("a40");
    next(); alloc_req = 2'b01; rel_valid = 2'b01; rel_preg = 12'd40; eg(1); ep(0, 42); en(22); push("rel40");
    next(); alloc_req = 2'b01; eg(1); ep(0, 40); en(22); push("got40");
    // Only slot 1 requests: it takes the lowest free, slot 0 outputs 0.
    next(); alloc_req = 2'b10; eg(1); ep(43, 0); en(21); push("slot1_only");
    next(); en(20); push("final");

    next();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
